// File: rtl/rcl_stream.sv
// rcl_stream -- line/circle relation classifier with a result FIFO.
//
// A job is three accepted beats carrying the line a*x + b*y + c = 0 on coef_L
// and the circle centre (m, n) plus squared radius k on coef_Q. For each job
// the block compares d^2 against (a^2 + b^2)*k, with d = a*m + b*n + c, and
// queues a 2-bit relation code: 00 separate, 01 tangent, 10 crossing.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   coef_L     line coefficient a, b, c by beat (signed, CW bits)
//   coef_Q     circle coefficient m, n (signed), k (unsigned) by beat
//   out_valid  FIFO head valid
//   out_ready  consumer pop when out_valid && out_ready
//   out        head relation code, 00 when out_valid = 0
//
// Optional build macro RCL_STREAM_STATS_EN adds cnt_sep, cnt_tan, cnt_cross:
// 16-bit saturating counts of popped codes 00, 01 and 10.
//
// Beat FSM
//   state | meaning
//   BEAT0 | waiting for a/m; only accepted while a FIFO credit is free
//   BEAT1 | a/m captured, waiting for b/n
//   BEAT2 | b/n captured, waiting for c/k; acceptance launches the pipeline

module rcl_stream #(
   parameter int CW    = 5,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] coef_L,
   input  logic [CW-1:0] coef_Q,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    out
`ifdef RCL_STREAM_STATS_EN
   ,
   output logic [15:0]   cnt_sep,
   output logic [15:0]   cnt_tan,
   output logic [15:0]   cnt_cross
`endif
);

   // d needs 2*CW+1 bits; one spare keeps the sum comfortably in range.
   localparam int DW = 2*CW + 2;
   localparam int KW = 2*DW;
   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;

   typedef enum logic [1:0] {
      BEAT0 = 2'd0,
      BEAT1 = 2'd1,
      BEAT2 = 2'd2
   } beat_e;

   beat_e                state_q, state_d;
   logic                 accept;
   logic                 take_beat0;
   logic                 push;
   logic                 pop;

   logic signed [CW-1:0] a_q, m_q, b_q, n_q, c_q;
   logic        [CW-1:0] k_q;
   logic                 cap_v_q;

   logic signed [DW-1:0] a_x, m_x, b_x, n_x, c_x;
   logic signed [DW-1:0] dist_d, nrm_d;
   logic signed [DW-1:0] dist_q, nrm_q;
   logic        [CW-1:0] rad_q;
   logic                 s1_v_q;

   logic signed [KW-1:0] dist_x, nrm_x, rad_x, lhs, rhs;
   logic        [1:0]    code;

   logic        [1:0]    mem_q [DEPTH];
   logic        [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic        [NW-1:0] cnt_q, cnt_d;
   logic        [NW-1:0] cred_q, cred_d;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) state_q <= BEAT0;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         case (state_q)
            BEAT0:   state_d = BEAT1;
            BEAT1:   state_d = BEAT2;
            BEAT2:   state_d = BEAT0;
            default: state_d = BEAT0;
         endcase
      end
   end

   // A job in progress already holds its credit, so only beat0 waits on one.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) in_ready = (state_q != BEAT0) || (cred_q < NW'(DEPTH));
   end

   assign accept     = in_valid && in_ready;
   assign take_beat0 = accept && (state_q == BEAT0);

   // ---------------------------------------------------------------- capture
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         m_q     <= '0;
         b_q     <= '0;
         n_q     <= '0;
         c_q     <= '0;
         k_q     <= '0;
         cap_v_q <= 1'b0;
      end else begin
         cap_v_q <= accept && (state_q == BEAT2);
         if (accept) begin
            case (state_q)
               BEAT0: begin
                  a_q <= coef_L;
                  m_q <= coef_Q;
               end
               BEAT1: begin
                  b_q <= coef_L;
                  n_q <= coef_Q;
               end
               BEAT2: begin
                  c_q <= coef_L;
                  k_q <= coef_Q;
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- stage 1
   assign a_x = {{(DW-CW){a_q[CW-1]}}, a_q};
   assign m_x = {{(DW-CW){m_q[CW-1]}}, m_q};
   assign b_x = {{(DW-CW){b_q[CW-1]}}, b_q};
   assign n_x = {{(DW-CW){n_q[CW-1]}}, n_q};
   assign c_x = {{(DW-CW){c_q[CW-1]}}, c_q};

   assign dist_d = a_x*m_x + b_x*n_x + c_x;
   assign nrm_d  = a_x*a_x + b_x*b_x;

   // The next job's beat0 may overwrite a/m on this same edge; the stage-1
   // register has already taken the old values by then.
   always_ff @(posedge clk) begin
      if (rst) begin
         dist_q <= '0;
         nrm_q  <= '0;
         rad_q  <= '0;
         s1_v_q <= 1'b0;
      end else begin
         s1_v_q <= cap_v_q;
         if (cap_v_q) begin
            dist_q <= dist_d;
            nrm_q  <= nrm_d;
            rad_q  <= k_q;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   assign dist_x = {{(KW-DW){dist_q[DW-1]}}, dist_q};
   assign nrm_x  = {{(KW-DW){nrm_q[DW-1]}}, nrm_q};
   assign rad_x  = {{(KW-CW){1'b0}}, rad_q};
   assign lhs    = dist_x * dist_x;
   assign rhs    = nrm_x * rad_x;

   always_comb begin
      code = 2'b10;
      if (lhs > rhs)       code = 2'b00;
      else if (lhs == rhs) code = 2'b01;
   end

   // ---------------------------------------------------------------- FIFO
   assign push      = s1_v_q;
   assign out_valid = !rst && (cnt_q != '0);
   assign pop       = out_valid && out_ready;
   assign out       = out_valid ? mem_q[rd_ptr_q] : 2'b00;

   assign cnt_d  = cnt_q  + NW'(push)       - NW'(pop);
   assign cred_d = cred_q + NW'(take_beat0) - NW'(pop);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= code;
   end

   // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         cred_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q  <= cnt_d;
         cred_q <= cred_d;
      end
   end

`ifdef RCL_STREAM_STATS_EN
   logic [15:0] cnt_sep_q, cnt_tan_q, cnt_cross_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_sep_q   <= '0;
         cnt_tan_q   <= '0;
         cnt_cross_q <= '0;
      end else if (pop) begin
         case (out)
            2'b00:   if (cnt_sep_q   != 16'hFFFF) cnt_sep_q   <= cnt_sep_q   + 16'd1;
            2'b01:   if (cnt_tan_q   != 16'hFFFF) cnt_tan_q   <= cnt_tan_q   + 16'd1;
            2'b10:   if (cnt_cross_q != 16'hFFFF) cnt_cross_q <= cnt_cross_q + 16'd1;
            default: ;
         endcase
      end
   end

   assign cnt_sep   = cnt_sep_q;
   assign cnt_tan   = cnt_tan_q;
   assign cnt_cross = cnt_cross_q;
`endif

endmodule

// File: tb/tb_rcl_stream.sv
// tb_rcl_stream -- self-checking bench for rcl_stream (CW=5, DEPTH=4).
// Inputs change 1 time unit after a rising edge; the DUT is observed on the
// falling edge, where a negedge monitor records accepted beats and popped
// codes. Expected codes come from the geometric relation computed directly
// with integer arithmetic on each accepted job.

module tb_rcl_stream;

   localparam int CW    = 5;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] coef_L;
   logic [CW-1:0] coef_Q;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out;
`ifdef RCL_STREAM_STATS_EN
   logic [15:0]   cnt_sep, cnt_tan, cnt_cross;
`endif

   int n_checks   = 0;
   int n_fail     = 0;
   int n_timeouts = 0;
   int stab_viol  = 0;

   logic [1:0] exp_all[$];
   logic [1:0] got_all[$];
   int         pop_cnt[3];

   int         mdl_beat = 0;
   longint     mdl_a, mdl_m, mdl_b, mdl_n;
   logic       hold_prev = 1'b0;
   logic [1:0] out_prev  = 2'b00;

   always #5 clk = ~clk;

   rcl_stream #(.CW(CW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .coef_L    (coef_L),
      .coef_Q    (coef_Q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
`ifdef RCL_STREAM_STATS_EN
      ,
      .cnt_sep   (cnt_sep),
      .cnt_tan   (cnt_tan),
      .cnt_cross (cnt_cross)
`endif
   );

   function automatic logic [1:0] relation(input longint a, b, c, m, n, k);
      longint d, k1, k2;
      d  = a*m + b*n + c;
      k1 = d*d;
      k2 = (a*a + b*b) * k;
      if (k1 > k2)  return 2'b00;
      if (k1 == k2) return 2'b01;
      return 2'b10;
   endfunction

   // Reference model: what the coming rising edge will do.
   always @(negedge clk) begin
      if (rst) begin
         mdl_beat = 0;
         while (exp_all.size() > got_all.size()) void'(exp_all.pop_back());
         pop_cnt   = '{0, 0, 0};
         hold_prev = 1'b0;
      end else begin
         if (hold_prev && !(out_valid === 1'b1 && out === out_prev)) stab_viol++;
         hold_prev = out_valid && !out_ready;
         out_prev  = out;
         if (out_valid && out_ready) begin
            got_all.push_back(out);
            if (out != 2'b11) pop_cnt[out]++;
         end
         if (in_valid && in_ready) begin
            case (mdl_beat)
               0: begin mdl_a = longint'($signed(coef_L)); mdl_m = longint'($signed(coef_Q)); end
               1: begin mdl_b = longint'($signed(coef_L)); mdl_n = longint'($signed(coef_Q)); end
               default: exp_all.push_back(relation(mdl_a, mdl_b, longint'($signed(coef_L)),
                                                   mdl_m, mdl_n, longint'(coef_Q)));
            endcase
            mdl_beat = (mdl_beat + 1) % 3;
         end
      end
   end

   // ---------------------------------------------------------------- stimulus helpers
   task automatic send_beat(input logic [CW-1:0] l, input logic [CW-1:0] q);
      in_valid = 1'b1;
      coef_L   = l;
      coef_Q   = q;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
      end
      n_timeouts++;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic gap(input int max_gap);
      int g;
      g = $urandom_range(0, max_gap);
      repeat (g) begin
         in_valid = 1'b0;
         coef_L   = CW'($urandom);
         coef_Q   = CW'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic send_job(input logic [CW-1:0] l0, q0, l1, q1, l2, q2, input int max_gap);
      gap(max_gap); send_beat(l0, q0);
      gap(max_gap); send_beat(l1, q1);
      gap(max_gap); send_beat(l2, q2);
   endtask

   task automatic send_rand_job(input int max_gap);
      send_job(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom),
               CW'($urandom), CW'($urandom), max_gap);
   endtask

   task automatic wait_drain();
      int i;
      for (i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (!out_valid && got_all.size() == exp_all.size()) break;
      end
      if (i == 300) n_timeouts++;
      @(posedge clk); #1;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; coef_L = '0; coef_Q = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++;
      if (out !== 2'b00) begin n_fail++; $display("FAIL reset_out: got %b want 00", out); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      int base;
      logic [1:0] want[4];
      want = '{2'b01, 2'b00, 2'b10, 2'b00};
      base = got_all.size();
      out_ready = 1'b1;
      send_job(5'd1, 5'd0, 5'd0, 5'd0, 5'b11110, 5'd4, 0);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_edge1: out_valid %b want 0", out_valid); end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_edge2: out_valid %b want 0", out_valid); end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out !== 2'b01)
         begin n_fail++; $display("FAIL latency_edge3: out_valid %b out %b want 1/01", out_valid, out); end
      @(posedge clk); #1;
      send_job(5'd1, 5'd0, 5'd0, 5'd0, 5'b11011, 5'd4, 0);
      send_job(5'd1, 5'd0, 5'd1, 5'd0, 5'd0, 5'd1, 0);
      send_job(5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'd31, 0);
      wait_drain();
      n_checks++;
      if (got_all.size() - base !== 4)
         begin n_fail++; $display("FAIL directed_count: got %0d want 4", got_all.size() - base); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got_all[base+i] !== want[i])
            begin n_fail++; $display("FAIL directed_code%0d: got %b want %b", i, got_all[base+i], want[i]); end
      end
   endtask

   task automatic test_backpressure();
      int base;
      time t0;
      logic [CW-1:0] l0, q0;
      base = got_all.size();
      out_ready = 1'b0;
      t0 = $time;
      for (int j = 0; j < 4; j++) send_rand_job(0);
      n_checks++;
      if (($time - t0) / 10 !== 12)
         begin n_fail++; $display("FAIL throughput: %0d cycles want 12", ($time - t0) / 10); end
      l0 = CW'($urandom); q0 = CW'($urandom);
      in_valid = 1'b1; coef_L = l0; coef_Q = q0;
      repeat (6) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL after_pop_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      send_beat(CW'($urandom), CW'($urandom));
      send_beat(CW'($urandom), CW'($urandom));
      repeat (8) @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_drain();
      n_checks++;
      if (got_all.size() - base !== 5)
         begin n_fail++; $display("FAIL stall_count: got %0d want 5", got_all.size() - base); end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (got_all[base+i] !== exp_all[base+i])
            begin n_fail++; $display("FAIL stall_order%0d: got %b want %b", i, got_all[base+i], exp_all[base+i]); end
      end
      n_checks++;
      if (stab_viol !== 0) begin n_fail++; $display("FAIL stall_stability: %0d changes want 0", stab_viol); end
   endtask

   task automatic test_random_stream();
      int   base;
      logic done;
      base = got_all.size();
      done = 1'b0;
      fork
         begin
            for (int j = 0; j < 40; j++) send_rand_job(2);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_drain();
      n_checks++;
      if (got_all.size() - base !== 40 || exp_all.size() - base !== 40)
         begin n_fail++; $display("FAIL random_count: got %0d model %0d want 40",
                                  got_all.size() - base, exp_all.size() - base); end
      for (int i = 0; i < 40; i++) begin
         n_checks++;
         if (got_all[base+i] !== exp_all[base+i])
            begin n_fail++; $display("FAIL random_code%0d: got %b want %b", i, got_all[base+i], exp_all[base+i]); end
      end
      n_checks++;
      if (stab_viol !== 0) begin n_fail++; $display("FAIL random_stability: %0d changes want 0", stab_viol); end
`ifdef RCL_STREAM_STATS_EN
      n_checks++;
      if (cnt_sep !== 16'(pop_cnt[0]) || cnt_tan !== 16'(pop_cnt[1]) || cnt_cross !== 16'(pop_cnt[2]))
         begin n_fail++; $display("FAIL stats: got %0d/%0d/%0d want %0d/%0d/%0d",
                                  cnt_sep, cnt_tan, cnt_cross, pop_cnt[0], pop_cnt[1], pop_cnt[2]); end
`endif
   endtask

   task automatic test_reset_midjob();
      int base;
      int viol;
      out_ready = 1'b1;
      send_beat(5'd3, 5'd2);
      send_beat(5'd1, 5'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      viol = 0;
      repeat (6) begin @(negedge clk); if (out_valid !== 1'b0) viol++; end
      n_checks++;
      if (viol !== 0) begin n_fail++; $display("FAIL midjob_reset_out_valid: %0d cycles valid want 0", viol); end
`ifdef RCL_STREAM_STATS_EN
      n_checks++;
      if (cnt_sep !== 16'd0 || cnt_tan !== 16'd0 || cnt_cross !== 16'd0)
         begin n_fail++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", cnt_sep, cnt_tan, cnt_cross); end
`endif
      @(posedge clk); #1;
      send_job(5'd1, 5'd0, 5'd1, 5'd0, 5'd0, 5'd1, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      viol = 0;
      repeat (6) begin @(negedge clk); if (out_valid !== 1'b0) viol++; end
      n_checks++;
      if (viol !== 0) begin n_fail++; $display("FAIL inflight_reset_out_valid: %0d cycles valid want 0", viol); end
      @(posedge clk); #1;
      base = got_all.size();
      send_job(5'd1, 5'd0, 5'd0, 5'd0, 5'b11110, 5'd4, 0);
      wait_drain();
      n_checks++;
      if (got_all.size() - base !== 1 || got_all[base] !== 2'b01)
         begin n_fail++; $display("FAIL fresh_job: count %0d code %b want 1/01",
                                  got_all.size() - base, got_all[base]); end
      n_checks++;
      if (n_timeouts !== 0) begin n_fail++; $display("FAIL handshake_timeouts: got %0d want 0", n_timeouts); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; coef_L = '0; coef_Q = '0;
      test_reset();
      test_directed();
      test_backpressure();
      test_random_stream();
      test_reset_midjob();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rcl_stream.md
RCL_STREAM -- requirements
Module: rcl_stream

Interface
REQ-001 The block SHALL have parameter CW, default 5, giving the width of signed coefficients (k unsigned), CW >= 3.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the result FIFO depth, power of two, >= 2.
REQ-003 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  in  1  input beat valid.
REQ-006 The block SHALL have port in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-007 The block SHALL have port coef_L  in  CW  line coefficient (a, b, c by beat).
REQ-008 The block SHALL have port coef_Q  in  CW  circle coefficient (m, n, k by beat).
REQ-009 The block SHALL have port out_valid  out  1  FIFO head valid.
REQ-010 The block SHALL have port out_ready  in  1  consumer pop when out_valid && out_ready.
REQ-011 The block SHALL have port out  out  2  relation code: 00 separate, 01 tangent, 10 crossing.

Function
REQ-012 A job SHALL be 3 accepted beats: beat0 a=coef_L, m=coef_Q; beat1 b, n; beat2 c, k (k unsigned).
REQ-013 The beat index SHALL advance only on acceptance; when in_valid drops mid-job, the index and captured values hold and the job is not aborted.
REQ-014 The block SHALL compute d=a*m+b*n+c, K1=d*d, K2=(a*a+b*b)*k at full precision with no truncation for any CW.
REQ-015 out SHALL be 00 if K1>K2, 01 if K1==K2, and 10 if K1<K2.
REQ-016 The datapath SHALL be two register stages: d and a*a+b*b are registered at edge T+1 after beat2 is accepted at edge T, and the code is written to the FIFO at edge T+2.
REQ-017 The block SHALL accept a new job beat0 in the cycle after beat2 of the previous job, allowing full throughput of one job per 3 cycles.
REQ-018 Credits SHALL be reserved on beat0 acceptance and released on pop.
REQ-019 in_ready SHALL be 1 when mid-job (index 1 or 2) or when reserved credits < DEPTH, else 0, so the FIFO never overflows.
REQ-020 out_valid SHALL equal FIFO non-empty, and out SHALL be the head code when out_valid=1 and 00 otherwise.
REQ-021 out SHALL be held stable while out_valid && !out_ready.
REQ-022 The FIFO SHALL allow a simultaneous push and pop in one cycle, including when full or empty-with-push, with occupancy unchanged and order preserved.
REQ-023 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Results SHALL leave in job-acceptance order.

Reset
REQ-025 While rst=1 at a clock edge, the beat index, captured coefficients, pipeline valids, FIFO pointers/occupancy and credits SHALL clear.
REQ-026 While rst=1, out_valid=0, out=00 and in_ready=0; in_ready=1 in the first cycle after rst falls.
REQ-027 A reset mid-job or mid-pipeline SHALL discard partial and in-flight jobs, and the next accepted beat SHALL be beat0.

Configuration
REQ-028 With macro RCL_STREAM_STATS_EN defined, the block SHALL add outputs cnt_sep, cnt_tan and cnt_cross (16 bits each), counting popped codes 00/01/10, saturating at 65535, and cleared by rst.
REQ-029 Without RCL_STREAM_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification (CW=5, DEPTH=4)
REQ-030 Beats (a,m)=(1,0), (b,n)=(0,0), (c,k)=(-2,4) with out_ready=1 -> out_valid=1 with out=01 two edges after beat2.
REQ-031 Beats (1,0), (0,0), (-5,4) -> out=00; beats (1,0), (1,0), (0,1) -> out=10.
REQ-032 Extreme inputs a=b=m=n=c=-16, k=31 (K1=246016, K2=15872) -> out=00 with no overflow.
REQ-033 With out_ready=0, stream 5 jobs -> in_ready=0 before beat0 of job 5; one pop -> job 5 accepted; the 5 codes emerge in order with out stable during the stall.
REQ-034 Toggle in_valid mid-job and pulse out_ready on the same edge as a push into a full FIFO -> no lost or duplicated result.
REQ-035 Assert rst after beat1 -> no out_valid; the next 3 beats are treated as a fresh job; stats counters read 0 if enabled.
